// File: rtl/pkt_fifo_ctrl_if.sv
// Writer/reader handshake bundle for the packet FIFO controller.
// The slave modport is the FIFO side; master is the decoder/consumer side.
interface pkt_fifo_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 9
);
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          wr_commit;
  logic          wr_discard;
  logic          wr_full;
  logic [AW:0]   wr_free;
  logic          wr_dropped;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_ready;
  logic [AW:0]   rd_level;

  modport slave (
    input  wr_en, wr_data, wr_commit, wr_discard, rd_ready,
    output wr_full, wr_free, wr_dropped, rd_valid, rd_data, rd_level
  );

  modport master (
    output wr_en, wr_data, wr_commit, wr_discard, rd_ready,
    input  wr_full, wr_free, wr_dropped, rd_valid, rd_data, rd_level
  );
endinterface

// File: rtl/pkt_fifo_ctrl.sv
// Packet FIFO over a simple dual-port bram: writes are staged until commit,
// reader sees only committed bytes through a show-ahead valid/ready stream.
module bram #(
  parameter int DW = 8,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          wr,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] din,
  input  logic          rd,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] dout
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr) mem[waddr] <= din;
    if (rd) dout <= mem[raddr];
  end
endmodule

module pkt_fifo_ctrl #(
  parameter int DW = 8,
  parameter int AW = 9
) (
  input  logic            clk,
  input  logic            rst,
  pkt_fifo_ctrl_if.slave  bus
);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

  logic [AW:0]   wptr, cptr, rptr, wptr_nxt, free;
  logic          ovf, rd_valid, dropped;
  logic          wr_acc, fetch, drop_pkt, rewind;
  logic [DW-1:0] dout;

  assign free           = DEPTH - (wptr - rptr);
  assign bus.wr_free    = free;
  assign bus.wr_full    = (free == '0);
  assign bus.rd_level   = cptr - rptr;
  assign bus.rd_valid   = rd_valid;
  assign bus.rd_data    = dout;
  assign bus.wr_dropped = dropped;

  assign wr_acc   = bus.wr_en && (free != '0);
  assign wptr_nxt = wptr + {{AW{1'b0}}, wr_acc};
  // An overflowed packet is rolled back on commit exactly as on discard.
  assign rewind   = bus.wr_discard || (bus.wr_commit && ovf);
  assign drop_pkt = bus.wr_commit && !bus.wr_discard && ovf && (wptr_nxt != cptr);
  // Only committed bytes are fetched, so raddr never meets a staged waddr.
  assign fetch    = (cptr != rptr) && (!rd_valid || bus.rd_ready);

  bram #(.DW(DW), .AW(AW)) u_mem (
    .clk   (clk),
    .wr    (wr_acc),
    .waddr (wptr[AW-1:0]),
    .din   (bus.wr_data),
    .rd    (fetch),
    .raddr (rptr[AW-1:0]),
    .dout  (dout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      cptr     <= '0;
      rptr     <= '0;
      rd_valid <= 1'b0;
      ovf      <= 1'b0;
      dropped  <= 1'b0;
    end else begin
      ovf     <= (bus.wr_commit || bus.wr_discard) ? 1'b0 : (ovf || (bus.wr_en && free == '0));
      dropped <= drop_pkt;
      if (rewind) begin
        wptr <= cptr;
      end else begin
        wptr <= wptr_nxt;
        if (bus.wr_commit) cptr <= wptr_nxt;
      end
      if (fetch) rptr <= rptr + ONE;
      if (fetch)             rd_valid <= 1'b1;
      else if (bus.rd_ready) rd_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pkt_fifo_ctrl.sv
// Directed bench for pkt_fifo_ctrl (AW=4): committed bytes go to a scoreboard
// queue, a negedge monitor compares every presented rd_data against its head.
module tb_pkt_fifo_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pkt_fifo_ctrl_if #(.DW(DW), .AW(AW)) bus ();
  pkt_fifo_ctrl #(.DW(DW), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] stg_q[$];
  bit rnd = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are stable at negedge, so rd_valid&&rd_ready here is the handshake
  // the next posedge will see.
  always @(negedge clk) begin
    if (!rst && bus.rd_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rd_valid", 32'(bus.rd_data), 32'hxxxx_xxxx);
      end else begin
        chk("rd_data", 32'(bus.rd_data), 32'(exp_q[0]));
        if (bus.rd_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    if (rnd) bus.rd_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] d, input bit accept);
    bus.wr_en = 1'b1;
    bus.wr_data = d;
    if (accept) stg_q.push_back(d);
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic commit(input bit drop);
    bus.wr_commit = 1'b1;
    step();
    bus.wr_commit = 1'b0;
    if (!drop) foreach (stg_q[i]) exp_q.push_back(stg_q[i]);
    stg_q.delete();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
    chk(tag, 32'(exp_q.size()), 32'd0);
    rnd = 0;
    bus.rd_ready = 1'b1;
    step();
    step();
  endtask

  initial begin
    bus.wr_en = 0; bus.wr_data = '0; bus.wr_commit = 0; bus.wr_discard = 0; bus.rd_ready = 1;
    #1;
    chk("rst_rd_valid", 32'(bus.rd_valid), 0);
    chk("rst_wr_free", 32'(bus.wr_free), 16);
    chk("rst_wr_full", 32'(bus.wr_full), 0);
    chk("rst_rd_level", 32'(bus.rd_level), 0);
    chk("rst_wr_dropped", 32'(bus.wr_dropped), 0);
    step();
    rst = 0;
    step();

    // basic packet, check latency and level countdown
    for (int i = 0; i < 5; i++) wr(8'(8'h10 + i), 1);
    chk("t1_free_staged", 32'(bus.wr_free), 11);
    chk("t1_level_staged", 32'(bus.rd_level), 0);
    commit(0);
    chk("t1_valid_at_commit", 32'(bus.rd_valid), 0);
    chk("t1_level_5", 32'(bus.rd_level), 5);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("t1_valid", 32'(bus.rd_valid), 1);
      chk("t1_level", 32'(bus.rd_level), 32'(5 - k));
    end
    step();
    chk("t1_valid_end", 32'(bus.rd_valid), 0);
    chk("t1_free_end", 32'(bus.wr_free), 16);
    chk("t1_drained", 32'(exp_q.size()), 0);

    // discard with a same-cycle write
    for (int i = 0; i < 3; i++) wr(8'(8'hA0 + i), 1);
    bus.wr_en = 1; bus.wr_data = 8'hA3; bus.wr_discard = 1;
    step();
    bus.wr_en = 0; bus.wr_discard = 0;
    stg_q.delete();
    step(); step();
    chk("t2_valid", 32'(bus.rd_valid), 0);
    chk("t2_free", 32'(bus.wr_free), 16);
    chk("t2_level", 32'(bus.rd_level), 0);
    wr(8'h01, 1);
    wr(8'h02, 1);
    commit(0);
    drain("t2_drain");

    // overflow: commit becomes a drop
    for (int i = 0; i < 16; i++) wr(8'(i), 1);
    chk("t3_full", 32'(bus.wr_full), 1);
    chk("t3_free0", 32'(bus.wr_free), 0);
    wr(8'hFF, 0);
    chk("t3_free0_after17", 32'(bus.wr_free), 0);
    commit(1);
    chk("t3_dropped", 32'(bus.wr_dropped), 1);
    chk("t3_level", 32'(bus.rd_level), 0);
    chk("t3_free", 32'(bus.wr_free), 16);
    step();
    chk("t3_dropped_once", 32'(bus.wr_dropped), 0);
    chk("t3_no_valid", 32'(bus.rd_valid), 0);
    // ovf cleared: next packet commits normally
    wr(8'h77, 1);
    commit(0);
    chk("t3_no_drop_after", 32'(bus.wr_dropped), 0);
    drain("t3_drain");

    // back-pressure hold
    bus.rd_ready = 0;
    for (int i = 0; i < 3; i++) wr(8'(8'h30 + i), 1);
    commit(0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", 32'(bus.rd_valid), 1);
      chk("t4_hold_level", 32'(bus.rd_level), 2);
      step();
    end
    bus.rd_ready = 1;
    step();
    chk("t4_b2b_valid1", 32'(bus.rd_valid), 1);
    chk("t4_b2b_level1", 32'(bus.rd_level), 1);
    step();
    chk("t4_b2b_valid2", 32'(bus.rd_valid), 1);
    chk("t4_b2b_level0", 32'(bus.rd_level), 0);
    step();
    chk("t4_valid_end", 32'(bus.rd_valid), 0);
    chk("t4_drained", 32'(exp_q.size()), 0);

    // wrap with random back-pressure
    for (int r = 0; r < 10; r++) begin
      rnd = 1;
      for (int i = 0; i < 7; i++) wr(8'($urandom), 1);
      commit(0);
      drain("t5_drain");
    end
    chk("t5_free", 32'(bus.wr_free), 16);
    chk("t5_level", 32'(bus.rd_level), 0);

    // reset mid-packet
    bus.rd_ready = 0;
    for (int i = 0; i < 3; i++) wr(8'(8'hC0 + i), 1);
    commit(0);
    wr(8'hD0, 1);
    wr(8'hD1, 1);
    chk("t6_pre_valid", 32'(bus.rd_valid), 1);
    rst = 1;
    #1;
    exp_q.delete();
    stg_q.delete();
    chk("t6_rst_valid", 32'(bus.rd_valid), 0);
    chk("t6_rst_free", 32'(bus.wr_free), 16);
    chk("t6_rst_full", 32'(bus.wr_full), 0);
    chk("t6_rst_level", 32'(bus.rd_level), 0);
    chk("t6_rst_dropped", 32'(bus.wr_dropped), 0);
    step();
    rst = 0;
    bus.rd_ready = 1;
    step();
    wr(8'h55, 1);
    wr(8'h66, 1);
    commit(0);
    drain("t6_drain");
    chk("t6_free_end", 32'(bus.wr_free), 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
